// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
// Two-stage pipelined WIDTH-bit subtractor: Diff = A - B - Bin, with borrow-out,
// signed-overflow and zero flags. The borrow chain is split at SPLIT: the low
// SPLIT bits are resolved in stage 1, the high WIDTH-SPLIT bits in stage 2.
// Valid/ready handshake on both sides with full backpressure.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      A/B/Bin valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   Bin        in   1      borrow-in
//   out_valid  out  1      Diff/flags valid
//   out_ready  in   1      consumer accepts result
//   Diff       out  WIDTH  (A - B - Bin) mod 2^WIDTH
//   Bout       out  1      unsigned A < B + Bin
//   Ovf        out  1      signed overflow of A - B - Bin
//   Zero       out  1      Diff == 0
module pipelined_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int unsigned HW = WIDTH - SPLIT;

    // Stage 1 state
    logic             r_s1_valid;
    logic [SPLIT-1:0] r_lo;
    logic             r_c1;
    logic [HW-1:0]    r_a_hi;
    logic [HW-1:0]    r_b_hi;
    logic             r_a_msb;
    logic             r_b_msb;

    // Stage 2 state
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_in_ready;
    logic [SPLIT:0]   w_lo_sum;
    logic [HW:0]      w_hi_sum;
    logic [WIDTH-1:0] w_diff;

    // Subtraction as A + ~B + !Bin; the carry out of each part is the inverted borrow.
    always_comb begin
        w_lo_sum = {1'b0, A[SPLIT-1:0]} + {1'b0, ~B[SPLIT-1:0]} + {{SPLIT{1'b0}}, ~Bin};
        w_hi_sum = {1'b0, r_a_hi} + {1'b0, ~r_b_hi} + {{HW{1'b0}}, r_c1};
        w_diff   = {w_hi_sum[HW-1:0], r_lo};
    end

    // s2 can take s1's result when empty or when its own result leaves this cycle.
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_s1_load  = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 data is cleared on reset so no X ever reaches the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo    <= '0;
            r_c1    <= 1'b0;
            r_a_hi  <= '0;
            r_b_hi  <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_s1_load) begin
            r_lo    <= w_lo_sum[SPLIT-1:0];
            r_c1    <= w_lo_sum[SPLIT];
            r_a_hi  <= A[WIDTH-1:SPLIT];
            r_b_hi  <= B[WIDTH-1:SPLIT];
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_s2_load) begin
            r_diff <= w_diff;
            r_bout <= ~w_hi_sum[HW];
            r_ovf  <= (r_a_msb != r_b_msb) && (w_diff[WIDTH-1] != r_a_msb);
            r_zero <= ~|w_diff;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign Diff      = r_diff;
    assign Bout      = r_bout;
    assign Ovf       = r_ovf;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor (WIDTH=32, SPLIT=16).
// Expected results come from an independent arithmetic model and are queued at
// input acceptance, then compared against the output whenever out_valid is high.
module tb_pipelined_subtractor;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Ovf;
    logic         Zero;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int n_acc    = 0;
    exp_t q[$];
    int pop_cyc[$];

    pipelined_subtractor #(
        .WIDTH(W),
        .SPLIT(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Diff     (Diff),
        .Bout     (Bout),
        .Ovf      (Ovf),
        .Zero     (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cycle);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        logic [W:0] full;
        longint sres;
        full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        sres   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (!rst) begin
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, Bin));
                n_acc <= n_acc + 1;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    check("diff", Diff, q[0].diff);
                    check("flags", {Bout, Ovf, Zero}, {q[0].bout, q[0].ovf, q[0].zero});
                    if (out_ready) begin
                        void'(q.pop_front());
                        pop_cyc.push_back(cycle);
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bit ok = 0;
        in_valid = 1'b1;
        A = a;
        B = b;
        Bin = bin;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        check("drain", ok, 1);
    endtask

    initial begin
        logic [W-1:0] held;
        int base;
        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", Diff, 0);
        check("rst_flags", {Bout, Ovf, Zero}, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Test 1: basic, with latency
        send(32'd10, 32'd3, 1'b0);
        check("lat_cycle1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_cycle2", out_valid, 1);
        check("t1_diff", Diff, 32'd7);
        drain();

        // Tests 2 and 3: wrap, zero, signed overflow, borrow across the split
        send(32'd0, 32'd1, 1'b0);
        send(32'd5, 32'd4, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0);
        send(32'h0001_0000, 32'd1, 1'b0);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Test 4: 8 back-to-back ops, results on consecutive cycles
        base = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", in_ready, 1);
            send(32'h1234_0000 + i * 32'h0001_1111, 32'h0000_FFFF * i, i[0]);
        end
        drain();
        check("stream_count", pop_cyc.size() - base, 8);
        check("stream_span", pop_cyc[base+7] - pop_cyc[base], 7);

        // Test 5: stall with backpressure; only 2 ops fit
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) send(32'h0001_0000 * (i + 1), 32'd7 + i, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                held = Diff;
                repeat (4) @(posedge clk);
                #1;
                check("stall_accepted", n_acc - base, 2);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_held", Diff, held);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_total", n_acc - base, 4);

        // Test 6: reset with both stages full
        out_ready = 1'b0;
        send(32'd100, 32'd1, 1'b0);
        send(32'd200, 32'd2, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_full", {out_valid, in_ready}, 2'b10);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_diff", Diff, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        send(32'd42, 32'd40, 1'b1);
        drain();

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule
